// File: rtl/reg_file.sv
// RISC-V integer register file: 32 x DWIDTH, two combinational read ports, one synchronous write port.
// Optional write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module reg_file #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AWIDTH-1:0] ra1,
    input  logic [AWIDTH-1:0] ra2,
    input  logic [AWIDTH-1:0] wa,
    input  logic [DWIDTH-1:0] wd,
    output logic [DWIDTH-1:0] rd1,
    output logic [DWIDTH-1:0] rd2
);

    localparam int unsigned NREG = 2 ** AWIDTH;

    // x0 has no storage; the array starts at x1
    logic [DWIDTH-1:0] regs_q [1:NREG-1];
    logic [DWIDTH-1:0] regs_d [1:NREG-1];
    logic              wr_en;

    assign wr_en = we && (wa != '0);

    // Writeback update; writes to x0 are dropped by wr_en
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wa] = wd;
        end
    end

    // Synchronous reset has priority over a coincident write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) begin
            rd1 = regs_q[ra1];
        end
        if (ra2 != '0) begin
            rd2 = regs_q[ra2];
        end
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight writeback value to a matching reader
        if (!rst && wr_en && (wa == ra1)) begin
            rd1 = wd;
        end
        if (!rst && wr_en && (wa == ra2)) begin
            rd2 = wd;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed plan plus randomized traffic against an array model.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [32];
    bit          model_valid = 0;

    reg_file #(.DWIDTH(32), .AWIDTH(5)) dut (
        .clk(clk), .rst(rst), .we(we),
        .ra1(ra1), .ra2(ra2), .wa(wa), .wd(wd),
        .rd1(rd1), .rd2(rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural state: reset clears everything, writes to x0 vanish
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            model_valid = 1;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
    end

    function automatic logic [31:0] expect_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (!rst && we && wa != 5'd0 && wa == ra) return wd;
`endif
        return model[ra];
    endfunction

    // Every-cycle compare, sampled mid-cycle once state is defined
    always @(negedge clk) begin
        if (model_valid) begin
            check("rd1_model", rd1, expect_rd(ra1));
            check("rd2_model", rd2, expect_rd(ra2));
        end
    end

    task automatic step(input logic r, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        rst = r; we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        // Arbitrary writes before the first reset
        for (int i = 1; i < 8; i++) step(0, 1, 5'(i), $urandom, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 0, 0, 5'(i), 5'(31 - i));
            #3;
            check("reset_rd1", rd1, 32'h0);
            check("reset_rd2", rd2, 32'h0);
        end

        // Basic write/read
        step(0, 1, 2, 32'h10838234, 0, 0);
        step(0, 1, 3, 32'hFEEDABBA, 1, 2);
        #3;
        check("basic_rd1_x1", rd1, 32'h0);
        check("basic_rd2_x2", rd2, 32'h10838234);
        step(0, 0, 0, 0, 3, 2);
        #3;
        check("basic_rd1_x3", rd1, 32'hFEEDABBA);
        check("basic_rd2_x2b", rd2, 32'h10838234);

        // x0 protection
        step(0, 1, 0, 32'hFFFFFFFF, 0, 2);
        #3;
        check("x0_during_write", rd1, 32'h0);
        step(0, 0, 0, 0, 0, 2);
        #3;
        check("x0_rd1", rd1, 32'h0);
        check("x0_rd2", rd2, 32'h10838234);

        // Write enable gating
        step(0, 0, 3, 32'h12345678, 3, 3);
        step(0, 0, 0, 0, 3, 3);
        #3;
        check("we_gating", rd1, 32'hFEEDABBA);

        // Same-address read/write on both ports
        step(0, 1, 5, 32'hAAAAAAAA, 0, 0);
        step(0, 1, 5, 32'h55555555, 5, 5);
        #3;
`ifdef REGFILE_BYPASS_EN
        check("same_addr_pre_rd1", rd1, 32'h55555555);
        check("same_addr_pre_rd2", rd2, 32'h55555555);
`else
        check("same_addr_pre_rd1", rd1, 32'hAAAAAAAA);
        check("same_addr_pre_rd2", rd2, 32'hAAAAAAAA);
`endif
        step(0, 0, 0, 0, 5, 5);
        #3;
        check("same_addr_post_rd1", rd1, 32'h55555555);
        check("same_addr_post_rd2", rd2, 32'h55555555);

        // Reset vs write collision
        step(0, 1, 7, 32'h0BADF00D, 0, 0);
        step(1, 1, 7, 32'hDEADBEEF, 7, 7);
        step(0, 0, 0, 0, 7, 5);
        #3;
        check("rst_collision_x7", rd1, 32'h0);
        check("rst_collision_x5", rd2, 32'h0);

        // Randomized traffic, read addresses biased toward the write address
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, 31));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), a, $urandom,
                 ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)));
        end

        @(posedge clk);
        #1;
        we = 1'b0; rst = 1'b0;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
